// File: rtl/collision_scan.sv
`default_nettype none
// ============================================================================
// Module      : collision_scan
// Description : Sequential player-vs-obstacle collision detector. On an
//               accepted start (one per game tick) it snapshots the player
//               position and the packed obstacle rectangles, then tests one
//               obstacle slot per clock against the fixed-x player box. After
//               the last slot it publishes the verdict and the lowest
//               colliding slot index with a one-cycle done pulse.
// Ports       :
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   one-cycle scan request
//   enable     in   scans accepted only while high
//   player_y   in   [9:0]  player box top edge
//   obstacle_x in   [20*NUM_OBS-1:0] slot i: {x_right, x_left}, 10b each
//   obstacle_y in   [18*NUM_OBS-1:0] slot i: {y_bottom, y_top}, 9b each
//   busy       out  high while scanning or reporting
//   done       out  one-cycle pulse when collision/hit_index update
//   collision  out  verdict of the last completed scan
//   hit_index  out  [3:0] lowest colliding slot, 4'hF when none
// Revision    : 1.0 - initial release
// ============================================================================
module collision_scan #(
  parameter int NUM_OBS  = 10,
  parameter int PLAYER_X = 160,
  parameter int PLAYER_W = 32,
  parameter int PLAYER_H = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   enable,
  input  logic [9:0]             player_y,
  input  logic [20*NUM_OBS-1:0]  obstacle_x,
  input  logic [18*NUM_OBS-1:0]  obstacle_y,
  output logic                   busy,
  output logic                   done,
  output logic                   collision,
  output logic [3:0]             hit_index
);

  localparam logic [3:0]  NO_HIT   = 4'hF;
  localparam logic [3:0]  LAST_IDX = 4'(NUM_OBS - 1);
  // Player box edges in 11 bits so player_y + PLAYER_H - 1 cannot wrap.
  localparam logic [10:0] P_LEFT   = 11'(PLAYER_X);
  localparam logic [10:0] P_RIGHT  = 11'(PLAYER_X + PLAYER_W - 1);
  localparam logic [10:0] P_HEIGHT = 11'(PLAYER_H - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  state_t state, state_next;

  logic [9:0]              snap_py;
  logic [20*NUM_OBS-1:0]   snap_x;
  logic [18*NUM_OBS-1:0]   snap_y;
  logic [3:0]              idx;
  logic                    hit_found_tmp;
  logic [3:0]              hit_index_tmp;

  // Unpacked views of the snapshot so the current slot is a simple array pick.
  logic [9:0] slot_xl [NUM_OBS];
  logic [9:0] slot_xr [NUM_OBS];
  logic [8:0] slot_yt [NUM_OBS];
  logic [8:0] slot_yb [NUM_OBS];

  for (genvar i = 0; i < NUM_OBS; i++) begin : g_unpack
    assign slot_xl[i] = snap_x[20*i      +: 10];
    assign slot_xr[i] = snap_x[20*i + 10 +: 10];
    assign slot_yt[i] = snap_y[18*i      +: 9];
    assign slot_yb[i] = snap_y[18*i + 9  +: 9];
  end

  logic [10:0] cur_xl, cur_xr, cur_yt, cur_yb;
  logic [10:0] p_top, p_bot;
  logic        slot_empty;
  logic        slot_hit;
  logic        start_accept;

  assign cur_xl = {1'b0,  slot_xl[idx]};
  assign cur_xr = {1'b0,  slot_xr[idx]};
  assign cur_yt = {2'b00, slot_yt[idx]};
  assign cur_yb = {2'b00, slot_yb[idx]};
  assign p_top  = {1'b0, snap_py};
  assign p_bot  = {1'b0, snap_py} + P_HEIGHT;

  // Inverted rectangles mark unused slots and must never report a hit.
  assign slot_empty = (cur_xl > cur_xr) || (cur_yt > cur_yb);
  // Inclusive bounds on both boxes, so touching edges count as a hit.
  assign slot_hit   = !slot_empty &&
                      (P_LEFT <= cur_xr) && (cur_xl <= P_RIGHT) &&
                      (p_top  <= cur_yb) && (cur_yt <= p_bot);

  assign start_accept = start && enable && (state == S_IDLE);
  assign busy         = (state != S_IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start_accept) state_next = S_SCAN;
      S_SCAN:   if (idx == LAST_IDX) state_next = S_REPORT;
      S_REPORT: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Datapath: snapshot, slot walk, hit latch and verdict publication.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_py       <= '0;
      snap_x        <= '0;
      snap_y        <= '0;
      idx           <= '0;
      hit_found_tmp <= 1'b0;
      hit_index_tmp <= NO_HIT;
      done          <= 1'b0;
      collision     <= 1'b0;
      hit_index     <= NO_HIT;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_accept) begin
            snap_py       <= player_y;
            snap_x        <= obstacle_x;
            snap_y        <= obstacle_y;
            idx           <= '0;
            hit_found_tmp <= 1'b0;
            hit_index_tmp <= NO_HIT;
          end
        end
        S_SCAN: begin
          // Slots are walked in ascending order, so the first hit is the lowest.
          if (slot_hit && !hit_found_tmp) begin
            hit_found_tmp <= 1'b1;
            hit_index_tmp <= idx;
          end
          if (idx != LAST_IDX) begin
            idx <= idx + 4'd1;
          end
        end
        S_REPORT: begin
          collision <= hit_found_tmp;
          hit_index <= hit_found_tmp ? hit_index_tmp : NO_HIT;
          done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/collision_scan.md
Name: collision_scan

Overview:
- Sequential collision detector between the game map and the game-logic FSM.
- Once per 60 Hz game tick it snapshots the player position and the packed obstacle arrays.
- It tests one obstacle rectangle per clock against the player box, then reports a collision verdict and the lowest hit index.
- game_logic consumes the verdict to switch gamemode to game-over.

Parameters:
- NUM_OBS, 10: number of obstacle slots in the packed buses.
- PLAYER_X, 160: player box left edge, pixels, fixed.
- PLAYER_W, 32: player box width, pixels.
- PLAYER_H, 32: player box height, pixels.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle scan request (game tick).
- enable  input  1  scans are accepted only while high (gamemode == playing).
- player_y  input  10  player box top edge.
- obstacle_x  input  20*NUM_OBS  slot i: [20i+9:20i] = x_left, [20i+19:20i+10] = x_right, inclusive.
- obstacle_y  input  18*NUM_OBS  slot i: [18i+8:18i] = y_top, [18i+17:18i+9] = y_bottom, inclusive.
- busy  output  1  high while capturing or scanning.
- done  output  1  one-cycle pulse when the verdict updates.
- collision  output  1  verdict of the last completed scan.
- hit_index  output  4  lowest colliding slot of the last scan; 4'hF if none.

Behaviour:
- Reset: synchronous, active-high, on clk; idempotent mid-scan.
  - State goes to IDLE.
  - busy=0, done=0, collision=0, hit_index=4'hF.
  - Scan index and internal hit registers are cleared.
- IDLE → SCAN: when start && enable && !busy.
  - Register player_y, obstacle_x and obstacle_y into snapshot registers on that edge.
  - Set busy=1 and index=0; clear hit_found_tmp.
- SCAN: one slot per cycle, slot = index. Compute in 11-bit unsigned to avoid wrap.
  - p_l=PLAYER_X, p_r=PLAYER_X+PLAYER_W-1, p_t=player_y, p_b=player_y+PLAYER_H-1.
  - Obstacle y fields are zero-extended.
  - Slot is empty (skipped) if x_left > x_right or y_top > y_bottom.
  - Hit when p_l<=x_right && x_left<=p_r && p_t<=y_bottom && y_top<=p_b. Edges touching counts as a hit.
  - On the first hit, latch hit_index_tmp=index; later hits do not overwrite it.
  - When index==NUM_OBS-1, go to REPORT; otherwise index+1.
- REPORT (1 cycle):
  - collision <= hit_found_tmp; hit_index <= hit_found_tmp ? hit_index_tmp : 4'hF.
  - done=1 for this cycle only; busy=0 from the next cycle; return to IDLE.
- Latency: start at edge N → done high in cycle N+NUM_OBS+1 (11 for default). Back-to-back scans every NUM_OBS+2 cycles.
- start while busy is ignored; it is not queued.
- start with enable=0 is ignored.
- Dropping enable mid-scan does not abort the scan.
- Input changes during a scan have no effect; the scan uses the snapshot only.
- collision and hit_index hold between done pulses. Only rst or a new REPORT changes them.

Test Plan:
1. rst=1 for 2 cycles, then released → busy=0, done=0, collision=0, hit_index=F. Pulse start with enable=0 → no busy, no done ever.
2. Setup: player_y=200; slot 3 x=[170,200], y=[220,250]; all other slots x_left=1, x_right=0. Pulse start → busy for 11 cycles, done exactly 11 cycles after start, collision=1, hit_index=3.
3. Edge touch: player_y=200; slot 0 x=[192,220], y=[200,231] → collision=0 (192 > p_r=191). Change x_left to 191 → collision=1, hit_index=0.
4. Multiple hits: overlapping rectangles in slots 7 and 2 → hit_index=2. Re-pulse start 3 cycles into the scan → ignored, single done.
5. Snapshot: start, then move slot 5 into overlap 2 cycles later → verdict collision=0. Next scan → collision=1, hit_index=5.
6. Assert rst during cycle 6 of a scan → next cycle busy=0, collision=0, hit_index=F, no done pulse.
